// File: rtl/led7seg_scan_driver.sv
// Multiplexed 7-segment scan driver: per-digit prescaled scan, frame-aligned load of a
// shadowed display value, hex decode with leading-zero blanking. Define LED7SEG_BLINK_EN for per-digit blinking.
module led7seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iLOAD_VALID,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic                    iBLANK_LZ,
`ifdef LED7SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
`endif
  output logic                    oLOAD_READY,
  output logic [6:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oDIG_EN,
  output logic                    oFRAME
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]         SEG_BLANK  = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h18;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d, shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    frame_q, frame_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    tick, boundary, upper_zero;
  logic [3:0]              nibble;
  logic                    blink_off;

`ifdef LED7SEG_BLINK_EN
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);
  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (boundary) begin
      if (blink_cnt_q == BC_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    blink_off = blink_q && iBLINK_MASK[idx_q];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`else
  logic unused_blink_frames;
  assign unused_blink_frames = |BLINK_FRAMES;
  assign blink_off = 1'b0;
`endif

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    frame_d  = boundary;

    // Pending blocks new loads, so a boundary apply and a new capture never coincide;
    // a load taken on the boundary edge waits for the next boundary.
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
    if (iLOAD_VALID && !pending_q) begin
      shadow_d  = iDATA;
      pending_d = 1'b1;
    end

    nibble     = display_q[{idx_q, 2'b00} +: 4];
    upper_zero = ((display_q >> {idx_q, 2'b00}) == '0);
    seg_d      = hex_to_seg(nibble);
    if (iBLANK_LZ && (idx_q != '0) && upper_zero) seg_d = SEG_BLANK;
    if (blink_off) seg_d = SEG_BLANK;
    dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      presc_q   <= '0;
      idx_q     <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_en_q  <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
    end
  end

  assign oLOAD_READY = ~pending_q;
  assign oSEG        = seg_q;
  assign oDIG_EN     = dig_en_q;
  assign oFRAME      = frame_q;

endmodule

// File: tb/tb_led7seg_scan_driver.sv
// Randomized scoreboard bench for led7seg_scan_driver; expected outputs come from a
// time-arithmetic reference model (digit = cycle/SCAN_DIV mod NUM_DIGITS, frames, blink phase).
module tb_led7seg_scan_driver;
  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data = 16'h0;
`ifdef LED7SEG_BLINK_EN
  logic [3:0]  blink_mask = 4'h0;
`endif
  logic        ready, frame;
  logic [6:0]  seg;
  logic [3:0]  dig_en;

  always #5 clk = ~clk;

  led7seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(B)) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iLOAD_VALID (load_valid),
    .iDATA       (data),
    .iBLANK_LZ   (blank_lz),
`ifdef LED7SEG_BLINK_EN
    .iBLINK_MASK (blink_mask),
`endif
    .oLOAD_READY (ready),
    .oSEG        (seg),
    .oDIG_EN     (dig_en),
    .oFRAME      (frame)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] data_masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  logic [12:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;
  bit started = 1'b0;

  function automatic int idx_of(int k);
    return (k / S) % N;
  endfunction

  function automatic bit phase_of(int k);
    return ((k / (S * N)) / B) % 2 == 1;
  endfunction

  // Driver + reference model: the model advances once per clock edge with the inputs
  // that were present at that edge, then pushes the outputs the DUT must show afterwards.
  initial begin
    int          n;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend, old_pend, fr;
    bit          c_rst, c_valid, c_lz;
    logic [15:0] c_data;
    logic [3:0]  c_mask, nib, dig;
    logic [6:0]  s;
    int          k, rst_left;
    n = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    c_rst = 1'b1; c_valid = 1'b0; c_lz = 1'b0; c_data = '0; c_mask = '0;
    rst_left = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (c_rst) begin
        n = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 4'hF, 7'h7F});
      end else begin
        n++;
        k   = idx_of(n - 1);
        nib = 4'(m_disp >> (4 * k));
        s   = seg_tab[nib];
        if (c_lz && k > 0 && (m_disp >> (4 * k)) == 16'h0) s = 7'h7F;
`ifdef LED7SEG_BLINK_EN
        if (phase_of(n - 1) && c_mask[k]) s = 7'h7F;
`endif
        dig = ~(4'b0001 << k);
        fr  = (n % (S * N)) == 0;
        old_pend = m_pend;
        if (fr && old_pend) begin
          m_disp = m_shadow;
          m_pend = 1'b0;
        end
        if (c_valid && !old_pend) begin
          m_shadow = c_data;
          m_pend   = 1'b1;
        end
        exp_q.push_back({~m_pend, fr, dig, s});
      end
      started = 1'b1;

      // next stimulus
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(0, 1);
      c_rst   = (rst_left > 0) || (cyc < 2);
      c_valid = ($urandom_range(0, 3) == 0);
      c_data  = 16'($urandom) & data_masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 49) == 0) c_lz = ~c_lz;
      if ($urandom_range(0, 99) == 0) c_mask = 4'($urandom);
      rst = c_rst; load_valid = c_valid; data = c_data; blank_lz = c_lz;
`ifdef LED7SEG_BLINK_EN
      blink_mask = c_mask;
`endif
    end
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Monitor: the DUT presents a fresh output word every cycle; compare at the falling edge.
  initial begin
    logic [12:0] e, act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {ready, frame, dig_en, seg};
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL scan_out t=%0t: got rdy=%b frm=%b dig=%b seg=%h, want rdy=%b frm=%b dig=%b seg=%h",
                   $time, act[12], act[11], act[10:7], act[6:0], e[12], e[11], e[10:7], e[6:0]);
        end
      end else if (started) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard_empty t=%0t: got no expectation, want one per cycle", $time);
      end
    end
  end
endmodule

// File: doc/led7seg_scan_driver.md
LED7SEG_SCAN_DRIVER -- requirements
Module: led7seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range 2..2^20.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per blink half-period; used only when LED7SEG_BLINK_EN is defined.
REQ-004 iCLK  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 iRST  input  1  reset; synchronous and active-high.
REQ-006 iLOAD_VALID  input  1  a new display value is offered on iDATA.
REQ-007 iDATA  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
REQ-008 iBLANK_LZ  input  1  enables leading-zero blanking.
REQ-009 oLOAD_READY  output  1  the block can accept a load this cycle.
REQ-010 oSEG  output  7  segment drive, active-low, bit order gfedcba.
REQ-011 oDIG_EN  output  NUM_DIGITS  digit enable, active-low, at most one bit low.
REQ-012 oFRAME  output  1  one-cycle pulse when a new frame starts.

Function
REQ-013 The block SHALL hold a prescaler counting 0..SCAN_DIV-1.
- At terminal count the prescaler SHALL return to 0.
- On the same edge the digit index SHALL advance by one, wrapping NUM_DIGITS-1 -> 0.
REQ-014 The frame boundary SHALL be the cycle in which the index wraps to 0.
- oFRAME SHALL be high for exactly the cycle following that edge.
REQ-015 Load handshake: a transfer occurs when iLOAD_VALID and oLOAD_READY are both 1 on a rising edge.
- iDATA SHALL be captured into the shadow register.
- A pending flag SHALL be set and oLOAD_READY SHALL go 0 from the next cycle.
REQ-016 While oLOAD_READY=0, iLOAD_VALID and iDATA SHALL be ignored.
REQ-017 At a frame boundary with pending set:
- the display register SHALL take the shadow value;
- pending SHALL clear and oLOAD_READY SHALL return to 1 in the next cycle.
REQ-018 A load accepted on the same edge as a frame boundary SHALL be applied at the following boundary, not the current one.
- This guarantees no frame ever mixes an old value and a new value.
REQ-019 oSEG and oDIG_EN SHALL be registered and SHALL reflect the current digit index one cycle after the index changes.
REQ-020 Decode (oSEG hex per nibble):
- 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
- 8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E
- blank = 7F
REQ-021 Leading-zero blanking: with iBLANK_LZ=1, each digit above the highest non-zero nibble of the display register SHALL output 7F.
- Digit 0 SHALL never be blanked by this rule, so a value of 0 displays "0".
REQ-022 iBLANK_LZ SHALL be sampled live, not through the shadow register.
REQ-023 oDIG_EN SHALL drive low the bit for the current digit index only, including while the digit is blanked.

Reset
REQ-024 While iRST=1 at a rising edge, the following SHALL be cleared:
- prescaler = 0, digit index = 0;
- display register = 0, shadow register = 0;
- pending = 0, blink state = 0.
REQ-025 Output values in the cycle after reset:
- oLOAD_READY = 1, oFRAME = 0;
- oSEG = 7F, oDIG_EN = all 1s (all digits off).
REQ-026 Reset mid-operation SHALL discard any pending load.
REQ-027 Reset SHALL take priority over a simultaneous load or frame boundary.
REQ-028 The first scan after reset SHALL begin with digit 0 after SCAN_DIV cycles.

Configuration
REQ-029 With macro LED7SEG_BLINK_EN defined:
- an input iBLINK_MASK, width NUM_DIGITS, SHALL exist;
- a frame counter SHALL toggle a blink phase every BLINK_FRAMES frame boundaries;
- during the off phase, each digit whose mask bit is 1 SHALL output oSEG=7F, with oDIG_EN unchanged.
REQ-030 Without LED7SEG_BLINK_EN, the iBLINK_MASK port and the frame counter SHALL be absent, and no digit ever blinks.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset then idle 20 cycles -> oDIG_EN cycles 1110, 1101, 1011, 0111 every 4 cycles; oSEG=40 on every digit; oFRAME pulses every 16 cycles.
REQ-032 Load 0x12AF mid-frame -> oLOAD_READY=0 until the next frame boundary; the displayed frame is old (0000) until the boundary, then oSEG shows 0E, 08, 24, 79 for digits 0..3.
REQ-033 Second load while oLOAD_READY=0, then a load on the boundary edge -> the second load is ignored; the boundary load appears one frame later.
REQ-034 Display 0x0050 with iBLANK_LZ=1 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40; display 0x0000 -> only digit 0 shows 40.
REQ-035 Assert iRST while pending -> after reset the display is 0000, oLOAD_READY=1, and the shadow value is never shown.
REQ-036 LED7SEG_BLINK_EN defined, iBLINK_MASK=0001 -> digit 0 alternates value/7F every 2 frames; digits 1-3 are steady.
